barrel_shift_pipe: RTL and testbench
====================================

# barrel_shift_pipe

Pipelined, multi-mode barrel shifter with valid/ready streaming on both sides. It generalises the team's combinational rotate-left shifter:
- four shift modes selected per transaction
- parametrised width
- optional per-bit pipelining
- tag sideband passed through
- full backpressure support

It sits in datapath pipelines feeding normalisers and bit-field extractors where one result per clock is required at high frequency.

## Interface
- DW, 8, data width in bits; DW must equal 2**SW (elaboration-time check, fatal error otherwise)
- SW, 3, shift-amount width in bits
- TW, 4, tag sideband width in bits (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept input this cycle
- in_data  in  DW  operand
- in_amt  in  SW  shift amount, 0..DW-1
- in_mode  in  2  00 rotate-left, 01 rotate-right, 10 logical-left (zero fill), 11 arithmetic-right (sign fill)
- in_tag  in  TW  opaque sideband, returned unchanged with the result
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  DW  shifted result
- out_tag  out  TW  tag of the transaction in out_data

## Operation
- Transfer on a port occurs when valid && ready are both high on a rising clk edge.
- Shift is decomposed into SW stages: stage k shifts by 2**k when amt[k]=1, otherwise passes data through; mode, remaining amount bits and tag travel with the data.
- Rotate: bits leaving one end re-enter at the other.
- Logical-left fills with 0.
- Arithmetic-right fills with in_data[DW-1], the original sign.
- in_amt=0 returns in_data unchanged in all modes.
- Pipeline control uses a per-stage valid bit. Stage k advances when it is empty or stage k+1 advances; the last stage advances when out_valid=0 or out_ready=1.
- in_ready = !valid_0 || stage 0 advances. This is combinational from out_ready through the ready chain; no skid buffer.
- Order preserved; no drop, no duplication.
- out_data/out_tag hold stable while out_valid=1 && out_ready=0.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.

## Timing
- Reset, asynchronous, effective immediately:
  - all stage valids 0, out_valid 0
  - out_data 0, out_tag 0
  - in_ready 1 once rst deasserts
  - in-flight transactions discarded
  - no output in the cycle after deassertion
- Latency from input accept edge to out_valid high:
  - SW cycles with pipelining enabled (3 for default)
  - 1 cycle without pipelining
- Throughput: one transaction per clk when out_ready held high.
- Capacity before in_ready falls under a continuous stall:
  - SW transactions with pipelining enabled
  - 1 transaction without pipelining
- Accept and output on the same edge is legal at full and partial occupancy.
- out_ready may change arbitrarily while out_valid=0.
- in_valid may deassert at any time.
- Data sampled only on accept.

## Configuration
- BARREL_SHIFT_PIPE_STAGE_EN:
  - Defined: one register per shift stage (SW register stages, latency SW, capacity SW).
  - Undefined: all SW stages are combinational into a single output register (latency 1, capacity 1).
- Functional results and handshake rules are identical in both builds; only latency and capacity differ.

## Test plan
All scenarios use DW=8, SW=3, built with BARREL_SHIFT_PIPE_STAGE_EN.
- Modes:
  - 0x81 rotate-left 1 -> 0x03
  - 0x81 rotate-right 1 -> 0xC0
  - 0x81 logical-left 3 -> 0x08
  - 0x80 arithmetic-right 3 -> 0xF0
  - 0x70 arithmetic-right 3 -> 0x0E
  - any mode, amt 0 -> input unchanged
- Streaming: 8 back-to-back inputs with tags 0..7, out_ready=1 -> first out_valid 3 cycles after first accept, then one result per cycle in tag order.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 -> in_ready falls after exactly 3 accepts; out_data stable while stalled; on release all results emerge in order, none lost or duplicated.
- Random valid/ready: 1000 random transactions with random in_valid/out_ready -> every result matches the reference model in order, tags intact.
- Reset mid-stream: assert rst with 2 transactions in flight -> out_valid falls immediately; no stale result emerges after deassertion; next input's result has correct latency.
- Macro-off build: same vectors -> identical results with latency 1; in_ready low while out_valid=1 && out_ready=0.

Source files
------------

// File: rtl/barrel_shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_pipe_if
// Description : Streaming bundle for barrel_shift_pipe. Carries the input
//               valid/ready channel (operand, amount, mode, tag) and the
//               output valid/ready channel (result, tag). The master side
//               is the producer/consumer around the shifter; the slave
//               side is the shifter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface barrel_shift_pipe_if #(
    parameter int DW = 8,
    parameter int SW = 3,
    parameter int TW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_amt;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_pipe
// Description : Pipelined four-mode barrel shifter (rotate-left,
//               rotate-right, logical-left, arithmetic-right) with
//               valid/ready streaming on both sides and a tag sideband.
//               The shift is split into SW binary-weighted stages.
//               Build option BARREL_SHIFT_PIPE_STAGE_EN:
//                 defined   -> one register per shift stage
//                              (latency SW, capacity SW)
//                 undefined -> all stages combinational into a single
//                              output register (latency 1, capacity 1)
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_pipe #(
    parameter int DW = 8,
    parameter int SW = 3,
    parameter int TW = 4
) (
    input wire                 clk,
    input wire                 rst,
    barrel_shift_pipe_if.slave bus
);

    localparam logic [1:0] c_MODE_ROL = 2'b00;
    localparam logic [1:0] c_MODE_ROR = 2'b01;
    localparam logic [1:0] c_MODE_LSL = 2'b10;

`ifdef BARREL_SHIFT_PIPE_STAGE_EN
    localparam int NR = SW;
`else
    localparam int NR = 1;
`endif

    if (DW != (1 << SW)) begin : g_bad_width
        $fatal(1, "barrel_shift_pipe: DW (%0d) must equal 2**SW (%0d)", DW, 1 << SW);
    end

    if (TW < 1) begin : g_bad_tag
        $fatal(1, "barrel_shift_pipe: TW must be at least 1");
    end

    // One binary-weighted shift stage: shift by s when en is set, else pass.
    // The arithmetic fill uses the sign of the original operand, carried
    // alongside the data, so later stages never depend on earlier results.
    function automatic logic [DW-1:0] f_shift(
        input logic [DW-1:0] d,
        input logic [1:0]    mode,
        input logic          sgn,
        input logic          en,
        input int            s
    );
        logic [DW-1:0] fill;
        logic [DW-1:0] r;
        fill = sgn ? ~({DW{1'b1}} >> s) : '0;
        case (mode)
            c_MODE_ROL: r = (d << s) | (d >> (DW - s));
            c_MODE_ROR: r = (d >> s) | (d << (DW - s));
            c_MODE_LSL: r = d << s;
            default:    r = (d >> s) | fill;
        endcase
        return en ? r : d;
    endfunction

    // Register stages. Each holds a valid bit plus the partially shifted
    // data and tag; intermediate stages also carry mode, sign and the
    // amount bits still to be applied.
    for (genvar r = 0; r < NR; r++) begin : g_reg
        logic          valid_q;
        logic          w_adv;
        logic          w_up_valid;
        logic [DW-1:0] data_q;
        logic [DW-1:0] data_d;
        logic [TW-1:0] tag_q;
        logic [TW-1:0] tag_d;

        if (r == 0) begin : g_up_in
            assign w_up_valid = bus.in_valid;
        end else begin : g_up_prev
            assign w_up_valid = g_reg[r-1].valid_q;
        end

        // A stage may take new content when it is empty or its content
        // moves on this edge; this lets bubbles collapse under a stall.
        if (r == NR - 1) begin : g_adv_last
            assign w_adv = !valid_q || bus.out_ready;
        end else begin : g_adv_mid
            assign w_adv = !valid_q || g_reg[r+1].w_adv;
        end

`ifdef BARREL_SHIFT_PIPE_STAGE_EN
        logic [DW-1:0] w_src_data;
        logic [1:0]    w_src_mode;
        logic          w_src_sign;
        logic          w_src_en;

        if (r == 0) begin : g_src_in
            assign w_src_data = bus.in_data;
            assign w_src_mode = bus.in_mode;
            assign w_src_sign = bus.in_data[DW-1];
            assign w_src_en   = bus.in_amt[0];
            assign tag_d      = bus.in_tag;
        end else begin : g_src_prev
            assign w_src_data = g_reg[r-1].data_q;
            assign w_src_mode = g_reg[r-1].g_ctrl.mode_q;
            assign w_src_sign = g_reg[r-1].g_ctrl.sign_q;
            assign w_src_en   = g_reg[r-1].g_ctrl.amt_q[0];
            assign tag_d      = g_reg[r-1].tag_q;
        end

        assign data_d = f_shift(w_src_data, w_src_mode, w_src_sign, w_src_en, 1 << r);

        if (r < NR - 1) begin : g_ctrl
            logic [1:0]      mode_q;
            logic            sign_q;
            logic [SW-2-r:0] amt_q;
            logic [SW-2-r:0] amt_d;

            if (r == 0) begin : g_amt_in
                assign amt_d = bus.in_amt[SW-1:1];
            end else begin : g_amt_prev
                assign amt_d = g_reg[r-1].g_ctrl.amt_q[SW-1-r:1];
            end

            // Control sideband follows the data into the next stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mode_q <= '0;
                    sign_q <= 1'b0;
                    amt_q  <= '0;
                end else if (w_adv && w_up_valid) begin
                    mode_q <= w_src_mode;
                    sign_q <= w_src_sign;
                    amt_q  <= amt_d;
                end
            end
        end
`else
        logic [DW-1:0] w_chain;

        // Whole shift ladder evaluated in one cycle ahead of the register.
        always_comb begin
            w_chain = bus.in_data;
            for (int k = 0; k < SW; k++) begin
                w_chain = f_shift(w_chain, bus.in_mode, bus.in_data[DW-1],
                                  bus.in_amt[k], 1 << k);
            end
        end

        assign data_d = w_chain;
        assign tag_d  = bus.in_tag;
`endif

        // Valid bit: reloads from upstream whenever the stage advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (w_adv) begin
                valid_q <= w_up_valid;
            end
        end

        // Payload: captured only on a real transfer, held otherwise so the
        // output stays stable while stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                tag_q  <= '0;
            end else if (w_adv && w_up_valid) begin
                data_q <= data_d;
                tag_q  <= tag_d;
            end
        end
    end

    assign bus.in_ready  = g_reg[0].w_adv;
    assign bus.out_valid = g_reg[NR-1].valid_q;
    assign bus.out_data  = g_reg[NR-1].data_q;
    assign bus.out_tag   = g_reg[NR-1].tag_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift_pipe
// Description : Directed and randomised self-checking bench for
//               barrel_shift_pipe (DW=8, SW=3, TW=4). Latency and capacity
//               expectations follow BARREL_SHIFT_PIPE_STAGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_pipe;

`ifdef BARREL_SHIFT_PIPE_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int CAP = LAT;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [7:0] bp_exp [6] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC};

    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.DW(8), .SW(3), .TW(4)) bus ();

    barrel_shift_pipe #(.DW(8), .SW(3), .TW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Bit-level reference: each result bit picks its source bit directly.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic [1:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00:   r[i] = d[(i - a + 8) % 8];
                2'b01:   r[i] = d[(i + a) % 8];
                2'b10:   r[i] = (i >= a) ? d[(i - a) & 7] : 1'b0;
                default: r[i] = (i + a < 8) ? d[(i + a) & 7] : d[7];
            endcase
        end
        return r;
    endfunction

    // Single transaction with out_ready high; entered and left at a negedge.
    task automatic run_one(input string nm, input logic [7:0] d, input logic [2:0] a,
                           input logic [1:0] m, input logic [3:0] t, input logic [7:0] e);
        int cyc;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        bus.in_tag    = t;
        #1 chk({nm, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, cyc, LAT);
        chk({nm, "_data"}, bus.out_data, e);
        chk({nm, "_tag"}, bus.out_tag, t);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        int in_idx, out_idx, cyc, acc0, first, last, stalls;
        int acc, got, sent, recv, seen;
        bit have, stable;
        logic [7:0]  held;
        logic [11:0] q[$];
        logic [11:0] exp_word;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // ---------------- reset state ----------------
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        rst = 1'b0;
        #1 chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("rst_no_output", bus.out_valid, 0);

        // ---------------- directed modes ----------------
        run_one("rol1",  8'h81, 3'd1, 2'b00, 4'h1, 8'h03);
        run_one("ror1",  8'h81, 3'd1, 2'b01, 4'h2, 8'hC0);
        run_one("lsl3",  8'h81, 3'd3, 2'b10, 4'h3, 8'h08);
        run_one("asr3n", 8'h80, 3'd3, 2'b11, 4'h4, 8'hF0);
        run_one("asr3p", 8'h70, 3'd3, 2'b11, 4'h5, 8'h0E);
        run_one("rol0",  8'hA5, 3'd0, 2'b00, 4'h6, 8'hA5);
        run_one("ror0",  8'hA5, 3'd0, 2'b01, 4'h7, 8'hA5);
        run_one("lsl0",  8'hA5, 3'd0, 2'b10, 4'h8, 8'hA5);
        run_one("asr0",  8'hA5, 3'd0, 2'b11, 4'h9, 8'hA5);
        run_one("rol7",  8'hB4, 3'd7, 2'b00, 4'hA, 8'h5A);
        run_one("ror4",  8'h3C, 3'd4, 2'b01, 4'hB, 8'hC3);
        run_one("lsl7",  8'h97, 3'd7, 2'b10, 4'hC, 8'h80);
        run_one("asr7",  8'h96, 3'd7, 2'b11, 4'hD, 8'hFF);

        // ---------------- streaming, 8 back-to-back ----------------
        bus.out_ready = 1'b1;
        in_idx = 0; out_idx = 0; cyc = 0; acc0 = -100; first = -1; last = -1; stalls = 0;
        while ((out_idx < 8) && (cyc < 40)) begin
            if (bus.out_valid) begin
                chk("stream_data", bus.out_data, 32'h1 << out_idx);
                chk("stream_tag", bus.out_tag, out_idx);
                if (out_idx == 0) first = cyc;
                last = cyc;
                out_idx++;
            end
            if (in_idx < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h01;
                bus.in_amt   = in_idx[2:0];
                bus.in_mode  = 2'b00;
                bus.in_tag   = in_idx[3:0];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid) begin
                if (bus.in_ready) begin
                    if (in_idx == 0) acc0 = cyc;
                    in_idx++;
                end else begin
                    stalls++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("stream_count", out_idx, 8);
        chk("stream_latency", first - acc0, LAT);
        chk("stream_gapless", last - first, 7);
        chk("stream_no_stall", stalls, 0);

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        acc = 0; have = 1'b0; stable = 1'b1; held = '0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h80;
            bus.in_amt   = acc[2:0];
            bus.in_mode  = 2'b11;
            bus.in_tag   = acc[3:0];
            #1 if (bus.in_ready) acc++;
            @(negedge clk);
            if (bus.out_valid) begin
                if (!have) begin
                    held = bus.out_data;
                    have = 1'b1;
                end else if (bus.out_data !== held) begin
                    stable = 1'b0;
                end
            end
        end
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_accepts", acc, CAP);
        chk("bp_stable", {have, stable}, 2'b11);
        chk("bp_held_data", held, 8'h80);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin
                if (got < 6) begin
                    chk("bp_data", bus.out_data, bp_exp[got]);
                    chk("bp_tag", bus.out_tag, got);
                end
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_count", got, CAP);

        // ---------------- random valid/ready ----------------
        sent = 0; recv = 0; cyc = 0;
        while ((recv < 1000) && (cyc < 20000)) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ((sent < 1000) && ($urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom_range(0, 255));
                bus.in_amt   = 3'($urandom_range(0, 7));
                bus.in_mode  = 2'($urandom_range(0, 3));
                bus.in_tag   = sent[3:0];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({bus.in_tag, ref_shift(bus.in_data, int'(bus.in_amt), bus.in_mode)});
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) begin
                    exp_word = q.pop_front();
                    chk("rnd_result", {bus.out_tag, bus.out_data}, exp_word);
                end else begin
                    chk("rnd_underflow", q.size(), 1);
                end
                recv++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rnd_received", recv, 1000);
        chk("rnd_queue_empty", q.size(), 0);

        // ---------------- reset mid-stream ----------------
        idle(2);
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (acc < 2) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h0F;
                bus.in_amt   = 3'(acc + 1);
                bus.in_mode  = 2'b00;
                bus.in_tag   = 4'(10 + acc);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1 if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("rstm_valid_before", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rstm_valid_async", bus.out_valid, 0);
        chk("rstm_data_async", bus.out_data, 0);
        chk("rstm_tag_async", bus.out_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rstm_no_stale", seen, 0);
        run_one("post_rst", 8'h3C, 3'd2, 2'b00, 4'h5, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
